// File: rtl/threshold_pkg.sv
// Shared definitions for the threshold frame sequencer: pixel width, reset
// threshold and the sequencer state encoding.
package threshold_pkg;

  localparam int PIX_W       = 8;
  localparam int DEFAULT_THR = 127;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

endpackage

// File: rtl/frame_pos_counter.sv
// Raster position counter: column wraps into row. IMG_W and IMG_H are powers
// of two, so both counters wrap naturally at their all-ones value.
module frame_pos_counter #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic is_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Next position: clear wins over increment; row advances on column wrap.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (inc) begin
      col_d = col_q + 1'b1;
      if (&col_q) begin
        row_d = row_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign is_last = (&col_q) & (&row_q);

endmodule

// File: rtl/threshold_frame_ctrl.sv
// Frame sequencer for the pixel threshold unit. Streams one frame of pixels
// into the unit, owns its threshold register, and re-times the unit's binary
// output into a valid/last stream. In auto mode the frame mean becomes the
// threshold for the following frame.
//
// Handshake: a pixel transfers on a rising edge where s_valid and s_ready are
// both 1; s_ready is registered and only high in RUN. The result stream has no
// backpressure: m_data/m_last are meaningful only while m_valid is 1.
module threshold_frame_ctrl
  import threshold_pkg::*;
#(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int PIX_W       = threshold_pkg::PIX_W,
  parameter int DEFAULT_THR = threshold_pkg::DEFAULT_THR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_auto,
  input  logic [PIX_W-1:0] cfg_thr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  output logic [PIX_W-1:0] thr_pixel,
  output logic [PIX_W-1:0] thr_value,
  input  logic             bin_in,
  output logic             m_valid,
  output logic             m_data,
  output logic             m_last,
  output logic             busy,
  output logic             frame_done,
  output state_t           dbg_state
);

  localparam int LOG_N = $clog2(IMG_W * IMG_H);
  localparam int SUM_W = PIX_W + LOG_N;

  state_t             state_q, state_d;
  logic               auto_q, auto_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [PIX_W-1:0]   thr_pixel_q, thr_pixel_d;
  logic [PIX_W-1:0]   thr_value_q, thr_value_d;
  logic               s_ready_q, s_ready_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic               l1_q, l1_d, l2_q, l2_d;

  logic accept;
  logic start_ok;
  logic is_last;

  assign accept   = s_valid & s_ready_q;
  // A start in the frame_done cycle belongs to the frame just finished.
  assign start_ok = (state_q == ST_IDLE) & start & ~frame_done_q;

  frame_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .inc     (accept),
    .is_last (is_last)
  );

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    auto_d       = auto_q;
    sum_d        = sum_q;
    thr_pixel_d  = thr_pixel_q;
    thr_value_d  = thr_value_q;
    s_ready_d    = s_ready_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    drain_cnt_d  = drain_cnt_q;
    // Result valid and last travel two stages, matching the unit's sample
    // edge plus its output register.
    v1_d = accept;
    v2_d = v1_q;
    l1_d = accept & is_last;
    l2_d = l1_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          auto_d = cfg_auto;
          if (!cfg_auto) begin
            thr_value_d = cfg_thr;
          end
          sum_d     = '0;
          busy_d    = 1'b1;
          s_ready_d = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          thr_pixel_d = s_pixel;
          if (auto_q) begin
            sum_d = sum_q + SUM_W'(s_pixel);
          end
          if (is_last) begin
            s_ready_d   = 1'b0;
            drain_cnt_d = 1'b0;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q) begin
          state_d = ST_UPDATE;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        // Truncating mean: the pixel count is a power of two.
        if (auto_q) begin
          thr_value_d = sum_q[LOG_N +: PIX_W];
        end
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, datapath registers and result pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      auto_q       <= 1'b0;
      sum_q        <= '0;
      thr_pixel_q  <= '0;
      thr_value_q  <= PIX_W'(DEFAULT_THR);
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drain_cnt_q  <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      l1_q         <= 1'b0;
      l2_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      auto_q       <= auto_d;
      sum_q        <= sum_d;
      thr_pixel_q  <= thr_pixel_d;
      thr_value_q  <= thr_value_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      drain_cnt_q  <= drain_cnt_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      l1_q         <= l1_d;
      l2_q         <= l2_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign thr_pixel  = thr_pixel_q;
  assign thr_value  = thr_value_q;
  assign m_valid    = v2_q;
  assign m_data     = v2_q & bin_in;
  assign m_last     = l2_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_threshold_frame_ctrl.sv
// Directed bench for threshold_frame_ctrl on a 4x4 frame, with a behavioural
// threshold unit (registered strict greater-than) closing the loop.
module tb_threshold_frame_ctrl;
  import threshold_pkg::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int N     = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cfg_auto = 1'b0;
  logic [7:0] cfg_thr = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_pixel = 8'd0;
  logic [7:0] thr_pixel;
  logic [7:0] thr_value;
  logic       bin_in;
  logic       m_valid;
  logic       m_data;
  logic       m_last;
  logic       busy;
  logic       frame_done;
  state_t     dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int st_cyc = 0;
  int done_cyc = 0;

  logic [1:0] exp_q[$];     // {last, data}
  logic [7:0] pix_a [N];
  logic [7:0] thr_exp;
  int         pix_idx;

  threshold_frame_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_auto   (cfg_auto),
    .cfg_thr    (cfg_thr),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pixel    (s_pixel),
    .thr_pixel  (thr_pixel),
    .thr_value  (thr_value),
    .bin_in     (bin_in),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural threshold unit: registered strict compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bin_in <= 1'b0;
    else     bin_in <= (thr_pixel > thr_value);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Result scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        check("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e[0]));
          check("m_last", 32'(m_last), 32'(e[1]));
        end
      end
      if (m_last && !m_valid) check("m_last_without_valid", 32'd1, 32'd0);
      if (frame_done) check("done_after_last", 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic do_start(input logic a, input logic [7:0] t);
    @(posedge clk); #1;
    start = 1'b1; cfg_auto = a; cfg_thr = t;
    @(posedge clk); #1;
    st_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic send_n(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int  waitc;
      bit  got;
      waitc = 0; got = 1'b0;
      s_valid = 1'b1;
      s_pixel = pix_a[pix_idx];
      while (!got && waitc < 50) begin
        @(negedge clk); got = s_ready;
        @(posedge clk); #1;
        waitc++;
      end
      check("accept_in_time", 32'(got), 32'd1);
      if (got) begin
        exp_q.push_back({pix_idx == N-1, pix_a[pix_idx] > thr_exp});
        pix_idx++;
      end
      s_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input bit poke);
    int c;
    bit seen;
    c = 0; seen = 1'b0;
    while (!seen && c < 200) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      c++;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    done_cyc = cyc;
    check("busy_at_done", 32'(busy), 32'd0);
    check("idle_at_done", 32'(dbg_state), 32'(ST_IDLE));
    if (poke) begin
      start = 1'b1; cfg_auto = 1'b0; cfg_thr = 8'd9;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_thr_value", 32'(thr_value), 32'd127);
    check("rst_thr_pixel", 32'(thr_pixel), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", 32'(dbg_state), 32'(ST_IDLE));

    // Manual frame, threshold 100, ramp 0..150 step 10: ones for 110..150.
    for (int i = 0; i < N; i++) pix_a[i] = 8'(i * 10);
    do_start(1'b0, 8'd100);
    thr_exp = 8'd100; pix_idx = 0;
    check("man_thr_loaded", 32'(thr_value), 32'd100);
    check("man_busy", 32'(busy), 32'd1);
    check("man_s_ready", 32'(s_ready), 32'd1);
    check("man_run", 32'(dbg_state), 32'(ST_RUN));
    send_n(N, 1'b0);
    check("man_ready_drop", 32'(s_ready), 32'd0);
    check("man_drain", 32'(dbg_state), 32'(ST_DRAIN));
    wait_done(1'b0);
    check("man_frame_cycles", 32'(done_cyc - st_cyc), 32'd19);
    check("man_thr_kept", 32'(thr_value), 32'd100);

    // Auto frame of 200s: applied threshold still 100, new mean 200.
    for (int i = 0; i < N; i++) pix_a[i] = 8'd200;
    do_start(1'b1, 8'd5);
    thr_exp = 8'd100; pix_idx = 0;
    check("auto_thr_not_loaded", 32'(thr_value), 32'd100);
    send_n(N, 1'b0);
    wait_done(1'b0);
    check("auto_mean_200", 32'(thr_value), 32'd200);

    // Next auto frame of 200s against 200: strict compare gives all zeros.
    do_start(1'b1, 8'd5);
    thr_exp = 8'd200; pix_idx = 0;
    send_n(N, 1'b0);
    wait_done(1'b0);
    check("auto_mean_200_again", 32'(thr_value), 32'd200);

    // Auto mixed frame summing to 1000: mean 62 after truncation.
    for (int i = 0; i < N; i++) pix_a[i] = (i % 4 == 0) ? 8'd250 : 8'd0;
    do_start(1'b1, 8'd5);
    thr_exp = 8'd200; pix_idx = 0;
    send_n(N, 1'b0);
    wait_done(1'b0);
    check("auto_mean_62", 32'(thr_value), 32'd62);

    // Manual frame with a bubble after every pixel, descending ramp.
    for (int i = 0; i < N; i++) pix_a[i] = 8'(150 - i * 10);
    do_start(1'b0, 8'd100);
    thr_exp = 8'd100; pix_idx = 0;
    send_n(N, 1'b1);
    wait_done(1'b0);
    check("bubble_all_results", 32'(exp_q.size()), 32'd0);

    // Start during RUN and in the frame_done cycle are both ignored.
    for (int i = 0; i < N; i++) pix_a[i] = 8'(i * 10);
    do_start(1'b0, 8'd50);
    thr_exp = 8'd50; pix_idx = 0;
    start = 1'b1; cfg_auto = 1'b1; cfg_thr = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    check("run_start_thr", 32'(thr_value), 32'd50);
    check("run_start_state", 32'(dbg_state), 32'(ST_RUN));
    send_n(N, 1'b0);
    wait_done(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("done_start_busy", 32'(busy), 32'd0);
    check("done_start_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("done_start_thr", 32'(thr_value), 32'd50);

    // Reset after 5 of 16 pixels accepted.
    do_start(1'b0, 8'd30);
    thr_exp = 8'd30; pix_idx = 0;
    send_n(5, 1'b0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_thr_value", 32'(thr_value), 32'd127);
    check("abort_thr_pixel", 32'(thr_pixel), 32'd0);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_still_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_no_busy", 32'(busy), 32'd0);

    // Start in IDLE is honoured after the abort.
    do_start(1'b0, 8'd40);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_thr", 32'(thr_value), 32'd40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
